// File: rtl/three_way_clmul_seq_pkg.sv
// Shared types and sizing helpers for the three-way limb-split carry-less multiplier.
package three_way_clmul_seq_pkg;

    typedef enum logic [2:0] {StIdle, StMul, StComb, StRed, StFin} state_e;

    // Limb width: the wider operand cut into three equal limbs.
    function automatic int unsigned calc_l(input int unsigned wa, input int unsigned wb);
        return ((wa > wb ? wa : wb) + 2) / 3;
    endfunction

    function automatic int unsigned calc_p(input int unsigned wa, input int unsigned wb);
        return wa + wb - 1;
    endfunction

    function automatic int unsigned calc_r(input int unsigned wa, input int unsigned wb,
                                           input int unsigned m);
        return calc_p(wa, wb) - m;
    endfunction

    localparam logic [12:0] Poly12 = 13'h1009;       // x^12 + x^3 + 1
    localparam logic [31:0] Poly31 = 32'h8000_0009;  // x^31 + x^3 + 1

endpackage

// File: rtl/clmul_serial_limb.sv
// Bit-serial L x L carry-less multiply engine: one shift-XOR step per enabled cycle.
module clmul_serial_limb #(
    parameter int unsigned L = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           enable,
    input  logic [L-1:0]   a_limb,
    input  logic [L-1:0]   b_limb,
    output logic [2*L-2:0] acc
);

    logic [L-1:0]   a_sh_q;
    logic [2*L-2:0] b_sh_q;
    logic [2*L-2:0] acc_q;

    // Shifting a right and b left is equivalent to acc ^= b << k when a[k] is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            acc_q  <= '0;
        end else if (clear) begin
            a_sh_q <= a_limb;
            b_sh_q <= (2*L-1)'(b_limb);
            acc_q  <= '0;
        end else if (enable) begin
            if (a_sh_q[0]) begin
                acc_q <= acc_q ^ b_sh_q;
            end
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q << 1;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/three_way_clmul_seq.sv
// Sequential carry-less multiplier: nine parallel limb engines, recombine, optional
// reduction modulo POLY, with a start/busy/done handshake.
module three_way_clmul_seq
    import three_way_clmul_seq_pkg::*;
#(
    parameter int unsigned WA   = 12,
    parameter int unsigned WB   = 13,
    parameter int unsigned M    = 12,
    parameter logic [M:0]  POLY = Poly12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reduce,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    output logic             busy,
    output logic             done,
    output logic [WA+WB-1:0] c
);

    localparam int unsigned L  = calc_l(WA, WB);
    localparam int unsigned P  = calc_p(WA, WB);
    localparam int unsigned EW = 3 * L;
    localparam int unsigned LW = 2 * L - 1;
    localparam int unsigned FW = 6 * L;
    localparam int unsigned KW = $clog2(L + 1);
    localparam int unsigned TW = $clog2(P + 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q;
    logic [TW-1:0] t_q;
    logic [P-1:0]  prod_q;
    logic          red_q;
    logic          busy_q;
    logic          done_q;
    logic [P:0]    c_q;

    logic [EW-1:0] a_ext, b_ext;
    logic [LW-1:0] acc [9];
    logic          eng_clear, eng_en;
    logic [FW-1:0] comb_full;
    logic [P-1:0]  poly_ext, red_term;

    assign a_ext     = EW'(a);
    assign b_ext     = EW'(b);
    assign eng_clear = (state_q == StIdle) && start;
    assign eng_en    = (state_q == StMul);

    for (genvar i = 0; i < 3; i++) begin : g_a
        for (genvar j = 0; j < 3; j++) begin : g_b
            clmul_serial_limb #(
                .L(L)
            ) u_limb (
                .clk   (clk),
                .rst   (rst),
                .clear (eng_clear),
                .enable(eng_en),
                .a_limb(a_ext[i*L +: L]),
                .b_limb(b_ext[j*L +: L]),
                .acc   (acc[3*i+j])
            );
        end
    end

    always_comb begin
        comb_full = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                comb_full = comb_full ^ (FW'(acc[3*i+j]) << (L * (i + j)));
            end
        end
    end

    assign poly_ext = P'(POLY);
    assign red_term = poly_ext << (t_q - TW'(M));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StMul;
            StMul:   if (k_q == KW'(L - 1)) state_d = StComb;
            StComb:  state_d = red_q ? StRed : StFin;
            StRed:   if (t_q == TW'(M)) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            t_q    <= '0;
            prod_q <= '0;
            red_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            c_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        red_q  <= reduce;
                        k_q    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                StMul: k_q <= k_q + 1'b1;
                StComb: begin
                    prod_q <= comb_full[P-1:0];
                    t_q    <= TW'(P - 1);
                end
                StRed: begin
                    if (prod_q[t_q]) begin
                        prod_q <= prod_q ^ red_term;
                    end
                    t_q <= t_q - 1'b1;
                end
                StFin: begin
                    c_q    <= {1'b0, prod_q};
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;

endmodule

// File: tb/tb_three_way_clmul_seq.sv
// Directed and randomised checks of three_way_clmul_seq against a plain GF(2) reference model.
module tb_three_way_clmul_seq;

    localparam int unsigned L1 = (13 + 2) / 3;
    localparam int unsigned R1 = 24 - 12;
    localparam int unsigned L2 = (32 + 2) / 3;
    localparam int unsigned R2 = 63 - 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, reduce = 1'b0;
    logic [11:0] a = '0;
    logic [12:0] b = '0;
    logic        busy, done;
    logic [24:0] c;

    logic        start2 = 1'b0, reduce2 = 1'b0;
    logic [31:0] a2 = '0, b2 = '0;
    logic        busy2, done2;
    logic [63:0] c2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    three_way_clmul_seq dut (
        .clk(clk), .rst(rst), .start(start), .reduce(reduce), .a(a), .b(b),
        .busy(busy), .done(done), .c(c)
    );

    three_way_clmul_seq #(
        .WA(32), .WB(32), .M(31), .POLY(32'h8000_0009)
    ) dut32 (
        .clk(clk), .rst(rst), .start(start2), .reduce(reduce2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .c(c2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Schoolbook carry-less product followed by polynomial long division.
    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input int wa, input int p, input int m,
                                            input logic [63:0] poly, input logic red);
        logic [63:0] r = '0;
        for (int i = 0; i < wa; i++) if (x[i]) r = r ^ (y << i);
        if (red) begin
            for (int t = p - 1; t >= m; t--) if (r[t]) r = r ^ (poly << (t - m));
        end
        return r;
    endfunction

    task automatic do_op(input logic [11:0] ta, input logic [12:0] tb, input logic tr,
                         output logic [24:0] res, output int lat, output int bcnt);
        @(negedge clk);
        a = ta; b = tb; reduce = tr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 12'($urandom); b = 13'($urandom); reduce = ~tr;
        lat = 0; bcnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy) bcnt++;
        end
        res = c;
    endtask

    task automatic do_op32(input logic [31:0] ta, input logic [31:0] tb, input logic tr,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        a2 = ta; b2 = tb; reduce2 = tr; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; a2 = $urandom; b2 = $urandom; reduce2 = ~tr;
        lat = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            lat++;
            if (done2) break;
        end
        res = c2;
    endtask

    initial begin
        logic [24:0] res;
        logic [63:0] res2;
        int          lat, bcnt, dcnt;
        logic [11:0] x;
        logic [12:0] y;
        logic [31:0] x2, y2;
        logic        r;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_c", 64'(c), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(12'h003, 13'h0005, 1'b0, res, lat, bcnt);
        check("small_c", 64'(res), 64'h000000F);
        check("small_lat", 64'(lat), 64'(L1 + 2));
        check("small_busy_cycles", 64'(bcnt), 64'(L1 + 1));
        check("small_busy_low", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("done_single_pulse", 64'(done), 64'd0);

        do_op(12'hFFF, 13'h1FFF, 1'b0, res, lat, bcnt);
        check("ones_c", 64'(res), 64'h0AAA555);
        check("ones_model", 64'(res), ref_mul(64'hFFF, 64'h1FFF, 12, 24, 12, 64'h1009, 1'b0));

        do_op(12'h800, 13'h0002, 1'b1, res, lat, bcnt);
        check("red_c", 64'(res), 64'h0000009);
        check("red_lat", 64'(lat), 64'(L1 + 2 + R1));

        // Second start mid-operation must be ignored.
        @(negedge clk);
        a = 12'h005; b = 13'h0007; reduce = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int n = 0; n < 100; n++) begin
            if (lat == 3) begin
                @(negedge clk);
                start = 1'b1; a = 12'hFFF; b = 13'h1FFF; reduce = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done) break;
        end
        check("ignore_c", 64'(c), 64'h1B);
        check("ignore_lat", 64'(lat), 64'(L1 + 2));
        // Back-to-back: accepted the cycle after done.
        do_op(12'hA5C, 13'h1234, 1'b0, res, lat, bcnt);
        check("b2b_c", 64'(res), ref_mul(64'hA5C, 64'h1234, 12, 24, 12, 64'h1009, 1'b0));
        check("b2b_lat", 64'(lat), 64'(L1 + 2));

        // Reset during MUL.
        @(negedge clk);
        a = 12'h7FF; b = 13'h0ABC; reduce = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mul_busy", 64'(busy), 64'd0);
        check("rst_mul_done", 64'(done), 64'd0);
        check("rst_mul_c", 64'(c), 64'd0);
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("rst_mul_no_done", 64'(dcnt), 64'd0);

        // Give c a non-zero value, then reset during RED.
        do_op(12'h123, 13'h0456, 1'b0, res, lat, bcnt);
        @(negedge clk);
        a = 12'hFFF; b = 13'h1FFF; reduce = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (L1 + 4) @(posedge clk);
        #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_red_busy", 64'(busy), 64'd0);
        check("rst_red_done", 64'(done), 64'd0);
        check("rst_red_c", 64'(c), 64'd0);
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("rst_red_no_done", 64'(dcnt), 64'd0);

        for (int v = 0; v < 1000; v++) begin
            x = 12'($urandom);
            y = 13'($urandom);
            r = 1'($urandom);
            do_op(x, y, r, res, lat, bcnt);
            check("rand_c", 64'(res), ref_mul(64'(x), 64'(y), 12, 24, 12, 64'h1009, r));
            check("rand_lat", 64'(lat), r ? 64'(L1 + 2 + R1) : 64'(L1 + 2));
        end

        for (int v = 0; v < 200; v++) begin
            x2 = $urandom;
            y2 = $urandom;
            r = 1'($urandom);
            do_op32(x2, y2, r, res2, lat);
            check("rand32_c", res2, ref_mul(64'(x2), 64'(y2), 32, 63, 31, 64'h8000_0009, r));
            check("rand32_lat", 64'(lat), r ? 64'(L2 + 2 + R2) : 64'(L2 + 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/three_way_clmul_seq.md
Name: three_way_clmul_seq

Overview:
- Parametrised sequential carry-less (GF(2)[x]) multiplier using a three-way limb split.
- Operands are zero-extended and cut into three limbs each. The nine limb cross-products are computed by nine bit-serial shift-XOR engines running in parallel, then recombined.
- Adds a start/busy/done handshake and an optional reduction mode modulo a fixed field polynomial.
- Sits in the large-integer/finite-field datapath as the next generation of the fixed 12x13 carry-less multiplier.

Parameters:
- WA, 12: width of operand a.
- WB, 13: width of operand b.
- M, 12: field degree used by reduction; requires M < WA+WB-1.
- POLY, 13'h1009: irreducible polynomial of degree M (M+1 bits, bit M set); default x^12+x^3+1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset (decided below).
- start  input  1  request; accepted only when busy=0.
- reduce  input  1  sampled with start: 1 = return the product mod POLY.
- a  input  WA  operand a; sampled on start acceptance.
- b  input  WB  operand b; sampled on start acceptance.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when c updates.
- c  output  WA+WB  result; bit WA+WB-1 is always 0; reduced result uses bits [M-1:0], upper bits 0.

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset: busy=0, done=0, c=0, FSM to IDLE, all accumulators and counters cleared.
- Reset mid-operation aborts: the operation is discarded, c=0, and no done pulse is produced.
- Derived constants:
  - L = ceil(max(WA,WB)/3).
  - Limbs a_i = a[iL+L-1:iL] and b_j likewise, each zero-extended to 3L bits.
  - Limb product width: 2L-1.
  - Product width: P = WA+WB-1.
  - Reduction cycles: R = P-M.
- FSM states: IDLE, MUL, COMB, RED, FIN.
- IDLE:
  - If start=1, latch a, b and reduce, clear the nine accumulators, counter k=0, busy<=1, go to MUL.
  - Otherwise hold; c is retained.
- MUL (L cycles):
  - Each engine (i,j), i,j in 0..2, does acc_ij ^= b_j << k if a_i[k]=1.
  - k increments every cycle; leave MUL when k=L-1.
- COMB (1 cycle):
  - prod = XOR over (i,j) of acc_ij << L*(i+j), truncated to P bits.
  - If reduce, go to RED with t=P-1; else go to FIN.
- RED (R cycles): if prod[t]=1, prod ^= POLY << (t-M); t decrements; exit after t=M.
- FIN (1 cycle): c <= prod, zero-extended; done<=1, busy<=0, go to IDLE.
- Latency from the start-accept edge to done high:
  - non-reduce: L+2 cycles;
  - reduce: L+2+R cycles.
  - Defaults (L=5, R=12): 7 and 19 cycles.
- Handshake rules:
  - start while busy=1 is ignored; no queueing.
  - start is accepted in the cycle after done (IDLE), giving back-to-back throughput of one result per L+3 (or L+3+R) cycles.
  - done is never high for two consecutive cycles.
- Input stability: a, b and reduce may change freely after acceptance without affecting the result.
- All arithmetic is GF(2): XOR only, no carries.

Decomposition:
- Shared package holds:
  - FSM state encoding;
  - functions for L, P and R;
  - default POLY constants for supported field degrees.
- One sub-module, clmul_serial_limb, is the natural split:
  - parametrised bit-serial L x L shift-XOR engine;
  - inputs: clear, enable, a-limb, b-limb;
  - output: 2L-1 bit accumulator;
  - instantiated 9 times.

Test Plan:
- a=12'h003, b=13'h0005, reduce=0 -> done exactly 7 cycles after accept; c=25'h000000F; busy high for 6 cycles.
- a=12'hFFF, b=13'h1FFF, reduce=0 -> c=25'h0AAA555.
- a=12'h800, b=13'h0002, reduce=1 -> done 19 cycles after accept; c=25'h0000009 (x^12 mod POLY).
- Second start pulsed mid-operation -> ignored; c reflects first operands; a new start the cycle after done is accepted and yields the correct second result.
- rst asserted during MUL or RED -> next cycle busy=0, done=0, c=0; no done pulse appears later.
- Randomised regression, 1000 vectors, both modes, plus one non-default parameter set (WA=WB=32, M=31, POLY=x^31+x^3+1) -> results match a reference carry-less multiply/reduce model.
